// File: rtl/fpga_stream_source.sv
// fpga_stream_source: Avalon-MM register window over a RAM with an AXI4-Stream dump port.
// Optional FPGA_STREAM_SRC_PATTERN_EN replaces RAM data with a counting pattern during dumps.
module fpga_stream_source #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        avs_address,
   input  logic              avs_chipselect,
   input  logic              avs_write_n,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic [DATA_W-1:0] axis4_m_tdata,
   output logic              axis4_m_tvalid,
   output logic              axis4_m_tlast,
   input  logic              axis4_m_tready
);
   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, DUMP = 2'd2, FLUSH = 2'd3} state_t;
   localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
`ifdef FPGA_STREAM_SRC_PATTERN_EN
   localparam logic [31:0] CTRL_MASK = 32'h8000_000f;
`else
   localparam logic [31:0] CTRL_MASK = 32'h8000_0007;
`endif
   state_t            state_q, state_d;
   logic [31:0]       ctrl_q, ctrl_d;
   logic              done_q, done_d, aborted_q, aborted_d;
   logic [ADDR_W-1:0] addr_q, addr_d, cur_q, cur_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, tdata_q, tdata_d, src;
   logic [ADDR_W:0]   len_q, len_d, rem_q, rem_d, len_eff;
   logic [CNT_W-1:0]  beats_q, beats_d;
   logic              tvalid_q, tvalid_d, tlast_q, tlast_d;
   logic              go, busy, wr, accept, abort, load, ram_we;
   logic [DATA_W-1:0] mem [2**ADDR_W];
`ifdef FPGA_STREAM_SRC_PATTERN_EN
   logic              pat_q, pat_d;
   logic [DATA_W-1:0] pcnt_q, pcnt_d;
   assign src = pat_q ? pcnt_q : mem[cur_q];
`else
   assign src = mem[cur_q];
`endif
   assign go      = ctrl_q[0];
   assign busy    = state_q != IDLE;
   assign wr      = avs_chipselect && !avs_write_n;
   assign accept  = tvalid_q && axis4_m_tready;
   assign abort   = state_q == DUMP && go && ctrl_q[2:1] == 2'b11;
   assign len_eff = len_q > DEPTH_L ? DEPTH_L : len_q;
   assign axis4_m_tdata  = tdata_q;
   assign axis4_m_tvalid = tvalid_q;
   assign axis4_m_tlast  = tlast_q;
   always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q & ~32'h8000_0001;
      done_d    = done_q;
      aborted_d = aborted_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      len_d     = len_q;
      rdata_d   = rdata_q;
      cur_d     = cur_q;
      rem_d     = rem_q;
      tdata_d   = tdata_q;
      tvalid_d  = tvalid_q;
      tlast_d   = tlast_q;
      ram_we    = 1'b0;
      load      = 1'b0;
`ifdef FPGA_STREAM_SRC_PATTERN_EN
      pat_d     = pat_q;
      pcnt_d    = pcnt_q;
`endif
      if (wr && avs_address == 3'd0 && (!busy || avs_writedata[2:1] == 2'b11))
         ctrl_d = avs_writedata & CTRL_MASK;
      if (wr && avs_address == 3'd2) addr_d = avs_writedata[ADDR_W-1:0];
      if (wr && avs_address == 3'd3) wdata_d = avs_writedata[DATA_W-1:0];
      if (wr && avs_address == 3'd4) len_d = avs_writedata[ADDR_W:0];
      beats_d = ctrl_q[31] ? '0 : beats_q + CNT_W'(accept);
      case (state_q)
         IDLE: if (go && ctrl_q[2:1] != 2'b11) begin
            done_d    = ctrl_q[2:1] == 2'b01 || (ctrl_q[2:1] == 2'b10 && len_eff == '0);
            aborted_d = 1'b0;
            cur_d     = addr_q;
            rem_d     = len_eff;
            ram_we    = ctrl_q[2:1] == 2'b01;
            state_d   = ctrl_q[2:1] == 2'b00 ? RD : (ctrl_q[2:1] == 2'b10 && len_eff != '0) ? DUMP : IDLE;
`ifdef FPGA_STREAM_SRC_PATTERN_EN
            pat_d     = ctrl_q[3];
            pcnt_d    = wdata_q;
`endif
         end
         RD: begin
            rdata_d = mem[cur_q];
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: if (accept && tlast_q) begin
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            done_d    = 1'b1;
            aborted_d = state_q == FLUSH;
            state_d   = IDLE;
         end else begin
            // Output register doubles as the prefetch stage: refill on first entry or on each accept.
            load = state_q == DUMP && (!tvalid_q || accept);
            if (load) begin
               tdata_d  = src;
               tvalid_d = 1'b1;
               tlast_d  = rem_q == (ADDR_W+1)'(1) || abort;
               cur_d    = cur_q + ADDR_W'(1);
               rem_d    = rem_q - (ADDR_W+1)'(1);
`ifdef FPGA_STREAM_SRC_PATTERN_EN
               pcnt_d   = pcnt_q + DATA_W'(1);
`endif
            end else if (abort) tlast_d = 1'b1;
            if (abort) state_d = FLUSH;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         ctrl_q    <= '0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         len_q     <= '0;
         rdata_q   <= '0;
         cur_q     <= '0;
         rem_q     <= '0;
         beats_q   <= '0;
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
`ifdef FPGA_STREAM_SRC_PATTERN_EN
         pat_q     <= 1'b0;
         pcnt_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         len_q     <= len_d;
         rdata_q   <= rdata_d;
         cur_q     <= cur_d;
         rem_q     <= rem_d;
         beats_q   <= beats_d;
         tdata_q   <= tdata_d;
         tvalid_q  <= tvalid_d;
         tlast_q   <= tlast_d;
`ifdef FPGA_STREAM_SRC_PATTERN_EN
         pat_q     <= pat_d;
         pcnt_q    <= pcnt_d;
`endif
      end
   end
   always_ff @(posedge clk) if (ram_we) mem[addr_q] <= wdata_q;
   always_comb
      case (avs_address)
         3'd0:    avs_readdata = ctrl_q;
         3'd1:    avs_readdata = {27'd0, aborted_q, state_q, done_q, busy};
         3'd2:    avs_readdata = 32'(addr_q);
         3'd3:    avs_readdata = 32'(wdata_q);
         3'd4:    avs_readdata = 32'(len_q);
         3'd5:    avs_readdata = 32'(rdata_q);
         3'd6:    avs_readdata = 32'(beats_q);
         default: avs_readdata = 32'({cur_q, rem_q, state_q});
      endcase
endmodule

// File: tb/tb_fpga_stream_source.sv
// tb_fpga_stream_source: randomized self-checking bench against a queue-based dump model.
module tb_fpga_stream_source;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic [2:0]  avs_address = 3'd0;
   logic        avs_chipselect = 1'b0, avs_write_n = 1'b1;
   logic [31:0] avs_writedata = 32'd0, avs_readdata;
   logic [7:0]  tdata;
   logic        tvalid, tlast, tready = 1'b0;
   int          checks = 0, failures = 0, beats_exp = 0;
   logic [7:0]  mem_m [32];
   logic [7:0]  got_d [$], exp_d [$];
   logic        got_l [$], exp_l [$];

   fpga_stream_source dut (
      .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_chipselect(avs_chipselect),
      .avs_write_n(avs_write_n), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
      .axis4_m_tdata(tdata), .axis4_m_tvalid(tvalid), .axis4_m_tlast(tlast), .axis4_m_tready(tready)
   );

   always #5 clk = ~clk;

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      avs_address = a; avs_writedata = d; avs_chipselect = 1'b1; avs_write_n = 1'b0;
      @(negedge clk);
      avs_chipselect = 1'b0; avs_write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      avs_address = a;
      #1 d = avs_readdata;
   endtask

   task automatic write_ram(input int a, input logic [7:0] v);
      bus_write(3'd2, 32'(a)); bus_write(3'd3, 32'(v)); bus_write(3'd0, 32'h3);
      mem_m[a] = v;
   endtask

   // Expected beats: LEN clamped to 32, optionally cut short by an abort.
   function automatic void model_dump(input int start, input int len, input int cut);
      int n;
      n = len > 32 ? 32 : len;
      if (cut >= 0 && cut < n) n = cut;
      exp_d.delete(); exp_l.delete();
      for (int i = 0; i < n; i++) begin
         exp_d.push_back(mem_m[(start + i) % 32]);
         exp_l.push_back(i == n - 1);
      end
   endfunction

   // Drives a dump and records accepted beats; stall violations and timeout go into viol.
   task automatic do_dump(input int start, input int len, input int mode, input int abort_after,
                          output int first_v, output int viol, output int span);
      logic pv, pl, pr, ab, fin;
      logic [7:0] pd;
      int hold, first_acc;
      got_d.delete(); got_l.delete();
      first_v = -1; viol = 0; span = 0; first_acc = -1; hold = 0;
      pv = 0; pl = 0; pr = 0; pd = 0; ab = 0; fin = 0;
      bus_write(3'd2, 32'(start)); bus_write(3'd4, 32'(len)); bus_write(3'd0, 32'h5);
      for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
         if (tvalid && first_v < 0) first_v = cyc;
         if (pv && !pr && (tvalid !== 1'b1 || tdata !== pd || (!ab && tlast !== pl))) viol++;
         if (abort_after >= 0 && !ab && got_d.size() == abort_after) begin
            ab = 1; hold = 4;
            avs_address = 3'd0; avs_writedata = 32'h7; avs_chipselect = 1'b1; avs_write_n = 1'b0;
         end else begin
            avs_chipselect = 1'b0; avs_write_n = 1'b1;
         end
         tready = hold > 0 ? 1'b0 : mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : ($urandom & 1) != 0;
         if (hold > 0) hold--;
         pv = tvalid; pd = tdata; pl = tlast; pr = tready;
         if (tvalid && tready) begin
            if (first_acc < 0) first_acc = cyc;
            span = cyc - first_acc + 1;
            got_d.push_back(tdata); got_l.push_back(tlast);
            fin = tlast;
         end
         @(negedge clk);
      end
      avs_chipselect = 1'b0; avs_write_n = 1'b1; tready = 1'b0;
      beats_exp += got_d.size();
      if (!fin) viol += 1000;
   endtask

   task automatic test_reset;
      logic [31:0] r;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 8'h00) begin
         failures++; $display("FAIL reset_outputs: got v=%b l=%b d=%h expected 0/0/00", tvalid, tlast, tdata);
      end
      reset_n = 1'b1;
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), r);
         checks++;
         if (r !== 32'd0) begin failures++; $display("FAIL reset_reg%0d: got %h expected 0", a, r); end
      end
   endtask

   task automatic test_write_read;
      logic [31:0] r, s;
      int a;
      logic [7:0] v;
      for (int k = 0; k < 4; k++) begin
         a = k == 0 ? 3 : int'($urandom % 32);
         v = k == 0 ? 8'hA5 : 8'($urandom);
         write_ram(a, v);
         bus_write(3'd2, 32'(a)); bus_write(3'd0, 32'h1);
         repeat (2) @(negedge clk);
         rd(3'd5, r); rd(3'd1, s);
         checks++;
         if (r !== 32'(v)) begin failures++; $display("FAIL read_rdata%0d: got %h expected %h", k, r, v); end
         checks++;
         if (s !== 32'h2) begin failures++; $display("FAIL read_stat%0d: got %h expected 2", k, s); end
      end
   endtask

   task automatic test_dump_wrap;
      int fv, viol, span;
      logic [31:0] r;
      for (int i = 0; i < 32; i++) write_ram(i, 8'(i));
      do_dump(30, 4, 0, -1, fv, viol, span);
      model_dump(30, 4, -1);
      checks++;
      if (fv !== 2) begin failures++; $display("FAIL wrap_latency: got %0d expected 2", fv); end
      checks++;
      if (viol !== 0 || span !== 4) begin failures++; $display("FAIL wrap_flow: got viol=%0d span=%0d expected 0/4", viol, span); end
      checks++;
      if (got_d.size() != exp_d.size()) begin failures++; $display("FAIL wrap_count: got %0d expected %0d", got_d.size(), exp_d.size()); end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
            failures++; $display("FAIL wrap_beat%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
         end
      end
      checks++;
      if (tvalid !== 1'b0) begin failures++; $display("FAIL wrap_idle: got tvalid=%b expected 0", tvalid); end
      rd(3'd6, r);
      checks++;
      if (r !== 32'(beats_exp)) begin failures++; $display("FAIL wrap_beats: got %0d expected %0d", r, beats_exp); end
      rd(3'd1, r);
      checks++;
      if (r !== 32'h2) begin failures++; $display("FAIL wrap_stat: got %h expected 2", r); end
   endtask

   task automatic test_stall;
      int fv, viol, span, st;
      st = int'($urandom % 32);
      do_dump(st, 8, 1, -1, fv, viol, span);
      model_dump(st, 8, -1);
      checks++;
      if (viol !== 0 || fv !== 2) begin failures++; $display("FAIL stall_flow: got viol=%0d first=%0d expected 0/2", viol, fv); end
      checks++;
      if (got_d.size() != exp_d.size()) begin failures++; $display("FAIL stall_count: got %0d expected %0d", got_d.size(), exp_d.size()); end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
            failures++; $display("FAIL stall_beat%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
         end
      end
   endtask

   task automatic test_abort;
      int fv, viol, span, st;
      logic [31:0] r;
      st = int'($urandom % 32);
      do_dump(st, 32, 0, 3, fv, viol, span);
      model_dump(st, 32, 4);
      checks++;
      if (viol !== 0) begin failures++; $display("FAIL abort_flow: got viol=%0d expected 0", viol); end
      checks++;
      if (got_d.size() != exp_d.size()) begin failures++; $display("FAIL abort_count: got %0d expected %0d", got_d.size(), exp_d.size()); end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
            failures++; $display("FAIL abort_beat%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
         end
      end
      rd(3'd1, r);
      checks++;
      if (r !== 32'h12) begin failures++; $display("FAIL abort_stat: got %h expected 12", r); end
      rd(3'd6, r);
      checks++;
      if (r !== 32'(beats_exp)) begin failures++; $display("FAIL abort_beats: got %0d expected %0d", r, beats_exp); end
   endtask

   task automatic test_len0_clamp;
      int fv, viol, span, seen, st;
      logic [31:0] r;
      seen = 0;
      bus_write(3'd4, 32'd0); bus_write(3'd0, 32'h5);
      for (int i = 0; i < 8; i++) begin
         if (tvalid) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen !== 0) begin failures++; $display("FAIL len0_valid: got %0d valid cycles expected 0", seen); end
      rd(3'd1, r);
      checks++;
      if (r !== 32'h2) begin failures++; $display("FAIL len0_stat: got %h expected 2", r); end
      st = int'($urandom % 32);
      do_dump(st, 40, 2, -1, fv, viol, span);
      model_dump(st, 40, -1);
      checks++;
      if (got_d.size() != 32 || viol !== 0) begin failures++; $display("FAIL clamp_count: got %0d viol=%0d expected 32/0", got_d.size(), viol); end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
            failures++; $display("FAIL clamp_beat%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
         end
      end
   endtask

   task automatic test_clr_cnt;
      logic [31:0] r;
      bus_write(3'd0, 32'h8000_0000);
      beats_exp = 0;
      rd(3'd6, r);
      checks++;
      if (r !== 32'd0) begin failures++; $display("FAIL clr_beats: got %0d expected 0", r); end
      rd(3'd0, r);
      checks++;
      if (r !== 32'd0) begin failures++; $display("FAIL clr_selfclear: got %h expected 0", r); end
   endtask

   task automatic test_reset_mid;
      int fv, viol, span, seen;
      logic [31:0] r;
      seen = 0;
      tready = 1'b0;
      bus_write(3'd2, 32'd7); bus_write(3'd4, 32'd10); bus_write(3'd0, 32'h5);
      for (int i = 0; i < 10 && !seen; i++) begin
         if (tvalid) seen = 1;
         else @(negedge clk);
      end
      checks++;
      if (seen !== 1) begin failures++; $display("FAIL midrst_start: got no tvalid expected tvalid"); end
      bus_write(3'd0, 32'h3);
      #1;
      checks++;
      if (avs_readdata !== 32'h4) begin failures++; $display("FAIL busy_ignore: got ctrl %h expected 4", avs_readdata); end
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      checks++;
      if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 8'h00) begin
         failures++; $display("FAIL midrst_outputs: got v=%b l=%b d=%h expected 0/0/00", tvalid, tlast, tdata);
      end
      reset_n = 1'b1;
      beats_exp = 0;
      rd(3'd1, r);
      checks++;
      if (r !== 32'd0) begin failures++; $display("FAIL midrst_stat: got %h expected 0", r); end
      do_dump(5, 3, 0, -1, fv, viol, span);
      model_dump(5, 3, -1);
      checks++;
      if (got_d.size() != exp_d.size() || viol !== 0 || fv !== 2) begin
         failures++; $display("FAIL midrst_redump: got %0d beats viol=%0d first=%0d expected %0d/0/2", got_d.size(), viol, fv, exp_d.size());
      end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
            failures++; $display("FAIL midrst_beat%0d: got %h/%b expected %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
         end
      end
   endtask

   task automatic test_random;
      int fv, viol, span, st, ln;
      logic [31:0] r;
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 4; j++) write_ram(int'($urandom % 32), 8'($urandom));
         st = int'($urandom % 32);
         ln = int'($urandom_range(1, 40));
         do_dump(st, ln, 2, -1, fv, viol, span);
         model_dump(st, ln, -1);
         checks++;
         if (got_d.size() != exp_d.size() || viol !== 0 || fv !== 2) begin
            failures++; $display("FAIL rand%0d_flow: got %0d beats viol=%0d first=%0d expected %0d/0/2", k, got_d.size(), viol, fv, exp_d.size());
         end
         for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
               failures++; $display("FAIL rand%0d_beat%0d: got %h/%b expected %h/%b", k, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
         end
      end
      rd(3'd6, r);
      checks++;
      if (r !== 32'(beats_exp)) begin failures++; $display("FAIL rand_beats: got %0d expected %0d", r, beats_exp); end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_dump_wrap;
      test_stall;
      test_abort;
      test_len0_clamp;
      test_clr_cnt;
      test_reset_mid;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
